// File: rtl/io_port_bridge_pkg.sv
// Shared types and default sizing for the processor I/O port bridge.
package io_port_bridge_pkg;

   localparam int unsigned IobDataWidth = 16;
   localparam int unsigned IobFifoDepth = 4;
   localparam int unsigned IobHoldoff   = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StFire = 2'd1,
      StHold = 2'd2
   } iob_state_e;

endpackage

// File: rtl/io_out_fifo.sv
// Show-ahead FIFO for processor OUT words; drops pushes when full and flags it stickily.
module io_out_fifo
   import io_port_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = IobDataWidth,
   parameter int unsigned DEPTH      = IobFifoDepth
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic [DATA_WIDTH-1:0]        push_data,
   input  logic                         pop,
   output logic [DATA_WIDTH-1:0]        pop_data,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         overflow
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]       count_q, count_d;
   logic                  overflow_q;
   logic                  full, empty, do_push, do_pop;

   assign full    = (count_q == CntW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop && !empty;
   // A simultaneous pop frees the slot, so a full FIFO can still take the push.
   assign do_push = push && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         if (push && !do_push) overflow_q <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;
   assign overflow = overflow_q;

endmodule

// File: rtl/io_port_bridge.sv
// Device-side bridge: buffers processor OUT words for a consumer and feeds producer
// words to processor IN with a one-cycle interrupt followed by a hold-off window.
module io_port_bridge
   import io_port_bridge_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = IobDataWidth,
   parameter int unsigned OUT_FIFO_DEPTH = IobFifoDepth,
   parameter int unsigned HOLDOFF_CYCLES = IobHoldoff
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] outPortData,
   input  logic                  outSignalEn,
   output logic [DATA_WIDTH-1:0] inPortData,
   output logic                  interruptSignal,
   input  logic [DATA_WIDTH-1:0] ext_in_data,
   input  logic                  ext_in_valid,
   output logic                  ext_in_ready,
   output logic [DATA_WIDTH-1:0] ext_out_data,
   output logic                  ext_out_valid,
   input  logic                  ext_out_ready,
   output logic                  overflow
);

   localparam int unsigned CntW = $clog2(HOLDOFF_CYCLES + 1);

   logic [$clog2(OUT_FIFO_DEPTH):0] fifo_count;

   io_out_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (OUT_FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (outSignalEn),
      .push_data (outPortData),
      .pop       (ext_out_ready),
      .pop_data  (ext_out_data),
      .count     (fifo_count),
      .overflow  (overflow)
   );

   assign ext_out_valid = (fifo_count != '0);

   iob_state_e            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] in_data_q, in_data_d;
   logic                  ready_idle;
   logic                  irq;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      in_data_d  = in_data_q;
      ready_idle = 1'b0;
      irq        = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready_idle = 1'b1;
            if (ext_in_valid) begin
               in_data_d = ext_in_data;
               state_d   = StFire;
            end
         end
         StFire: begin
            irq     = 1'b1;
            cnt_d   = CntW'(HOLDOFF_CYCLES - 1);
            state_d = StHold;
         end
         StHold: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         in_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         in_data_q <= in_data_d;
      end
   end

   // State resets to IDLE, so ready must be masked explicitly while reset is held.
   assign ext_in_ready    = ready_idle & reset;
   assign interruptSignal = irq;
   assign inPortData      = in_data_q;

endmodule
